control_sequencer: RTL

Sequences one instruction at a time through the 10-bit datapath: latches the instruction word, steps a 2-bit time counter (T0–T3), and decodes per-step bus-drive, register-load and ALU controls. Its `Time` and `Done` outputs feed the front-panel display logic. Its control outputs drive the register file, the A/G ALU latches and the external-data bus driver.

---
 rtl/control_sequencer.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Steps one instruction at a time through the 10-bit datapath. The block
// latches the instruction word on a start event. It then walks a 2-bit step
// counter (T0 idle, T1..T3 active) and decodes, from the registered step and
// the registered instruction, the bus-drive, register-load and ALU controls
// for each step.
//
// Ports
//   Clock   in   1  system clock, all state on the rising edge
//   Resetb  in   1  asynchronous active-low reset
//   Exec    in   1  execute button level (asynchronous); its synchronized
//                   rising edge starts an instruction
//   Stepb   in   1  active-low step button (asynchronous), used only with
//                   SINGLE_STEP_EN
//   Instr   in  10  instruction word: [9:8] Rx, [7:6] Ry, [3:0] opcode
//   Time    out  2  current step (0 = T0 idle, 1..3 = T1..T3)
//   Done    out  1  high during the final step of an instruction
//   Rin     out  4  one-hot register load enable
//   Rout    out  4  one-hot register bus drive
//   ENW     out  1  external data drives the bus
//   IMMout  out  1  zero-extended immediate drives the bus
//   Ain     out  1  load ALU A latch
//   Gin     out  1  load ALU G latch
//   Gout    out  1  G latch drives the bus
//   ALUcn   out  2  ALU op: 00 add, 01 sub, 10 invert, 11 bit-reverse
//   IR      out 10  latched instruction
//
// Configuration macro: SINGLE_STEP_EN
//   When this macro is defined, each step from T1 to T3 advances only on a
//   synchronized falling edge of Stepb. When it is undefined, Stepb is ignored
//   and a step advances on every clock.
// -----------------------------------------------------------------------------
module control_sequencer (
    input  logic       Clock,
    input  logic       Resetb,
    input  logic       Exec,
    input  logic       Stepb,
    input  logic [9:0] Instr,
    output logic [1:0] Time,
    output logic       Done,
    output logic [3:0] Rin,
    output logic [3:0] Rout,
    output logic       ENW,
    output logic       IMMout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic [1:0] ALUcn,
    output logic [9:0] IR
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    // Two-bit register index to one-hot enable.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] vec;
        vec = 4'b0000;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    step_e       step_r;
    step_e       step_next_s;
    logic [9:0]  ir_r;

    logic        exec_meta_r;
    logic        exec_sync_r;
    logic        exec_prev_r;
    logic [1:0]  fill_r;
    logic        armed_r;
    logic        fill_done_s;
    logic        start_s;
    logic        advance_s;

    logic [1:0]  rx_s;
    logic [1:0]  ry_s;
    logic [3:0]  op_s;

    logic        done_s;
    logic [3:0]  rin_s;
    logic [3:0]  rout_s;
    logic        enw_s;
    logic        imm_s;
    logic        ain_s;
    logic        gin_s;
    logic        gout_s;
    logic [1:0]  alucn_s;

    // Exec synchronizer and edge detection.
    // fill_r waits until the synchronizer holds real samples. armed_r is set
    // only after a genuine low level has been seen. Because of this, an Exec
    // level held high across reset release cannot look like a rising edge.
    always_ff @(posedge Clock or negedge Resetb) begin
        if (!Resetb) begin
            exec_meta_r <= 1'b0;
            exec_sync_r <= 1'b0;
            exec_prev_r <= 1'b0;
            fill_r      <= 2'd0;
            armed_r     <= 1'b0;
        end else begin
            exec_meta_r <= Exec;
            exec_sync_r <= exec_meta_r;
            exec_prev_r <= exec_sync_r;
            if (fill_r != 2'd2) begin
                fill_r <= fill_r + 2'd1;
            end else begin
                fill_r <= fill_r;
            end
            armed_r <= armed_r | (fill_done_s & ~exec_sync_r);
        end
    end

    assign fill_done_s = (fill_r == 2'd2);
    assign start_s     = armed_r & exec_sync_r & ~exec_prev_r;

`ifdef SINGLE_STEP_EN
    logic step_meta_r;
    logic step_sync_r;
    logic step_prev_r;

    // Stepb synchronizer. The flops reset low, so the first high sample looks
    // like a rising edge. A rising edge is never taken as a step.
    always_ff @(posedge Clock or negedge Resetb) begin
        if (!Resetb) begin
            step_meta_r <= 1'b0;
            step_sync_r <= 1'b0;
            step_prev_r <= 1'b0;
        end else begin
            step_meta_r <= Stepb;
            step_sync_r <= step_meta_r;
            step_prev_r <= step_sync_r;
        end
    end

    assign advance_s = step_prev_r & ~step_sync_r;
`else
    logic unused_stepb_s;
    assign unused_stepb_s = Stepb;
    assign advance_s      = 1'b1;
`endif

    // Step register and instruction latch.
    always_ff @(posedge Clock or negedge Resetb) begin
        if (!Resetb) begin
            step_r <= T0;
            ir_r   <= 10'd0;
        end else begin
            step_r <= step_next_s;
            if ((step_r == T0) && start_s) begin
                ir_r <= Instr;
            end else begin
                ir_r <= ir_r;
            end
        end
    end

    assign rx_s = ir_r[9:8];
    assign ry_s = ir_r[7:6];
    assign op_s = ir_r[3:0];

    // Per-step control decode and next-step selection.
    always_comb begin
        done_s      = 1'b0;
        rin_s       = 4'b0000;
        rout_s      = 4'b0000;
        enw_s       = 1'b0;
        imm_s       = 1'b0;
        ain_s       = 1'b0;
        gin_s       = 1'b0;
        gout_s      = 1'b0;
        alucn_s     = 2'b00;
        step_next_s = step_r;

        case (step_r)
            T1: begin
                case (op_s)
                    4'b0000: begin
                        enw_s  = 1'b1;
                        rin_s  = onehot4(rx_s);
                        done_s = 1'b1;
                    end
                    4'b0001: begin
                        rout_s = onehot4(ry_s);
                        rin_s  = onehot4(rx_s);
                        done_s = 1'b1;
                    end
                    4'b0010, 4'b0011, 4'b0110, 4'b0111: begin
                        rout_s = onehot4(rx_s);
                        ain_s  = 1'b1;
                    end
                    4'b0100, 4'b0101: begin
                        rout_s  = onehot4(ry_s);
                        gin_s   = 1'b1;
                        alucn_s = {1'b1, op_s[0]};
                    end
                    default: begin
                        // Illegal opcodes finish at once and enable nothing.
                        done_s = 1'b1;
                    end
                endcase
            end
            T2: begin
                case (op_s)
                    4'b0010, 4'b0011: begin
                        rout_s  = onehot4(ry_s);
                        gin_s   = 1'b1;
                        alucn_s = {1'b0, op_s[0]};
                    end
                    4'b0110, 4'b0111: begin
                        imm_s   = 1'b1;
                        gin_s   = 1'b1;
                        alucn_s = {1'b0, op_s[0]};
                    end
                    4'b0100, 4'b0101: begin
                        gout_s = 1'b1;
                        rin_s  = onehot4(rx_s);
                        done_s = 1'b1;
                    end
                    default: begin
                        done_s = 1'b0;
                    end
                endcase
            end
            T3: begin
                case (op_s)
                    4'b0010, 4'b0011, 4'b0110, 4'b0111: begin
                        gout_s = 1'b1;
                        rin_s  = onehot4(rx_s);
                        done_s = 1'b1;
                    end
                    default: begin
                        done_s = 1'b0;
                    end
                endcase
            end
            default: begin
                done_s = 1'b0;
            end
        endcase

        if (step_r == T0) begin
            if (start_s) begin
                step_next_s = T1;
            end else begin
                step_next_s = T0;
            end
        end else if (advance_s) begin
            if (done_s) begin
                step_next_s = T0;
            end else begin
                step_next_s = step_e'(step_r + 2'd1);
            end
        end else begin
            step_next_s = step_r;
        end
    end

    assign Time   = step_r;
    assign IR     = ir_r;
    assign Done   = done_s;
    assign Rin    = rin_s;
    assign Rout   = rout_s;
    assign ENW    = enw_s;
    assign IMMout = imm_s;
    assign Ain    = ain_s;
    assign Gin    = gin_s;
    assign Gout   = gout_s;
    assign ALUcn  = alucn_s;

endmodule
